lite_16_mem_arbiter: RTL
========================

# lite_16_mem_arbiter

Three-port round-robin arbiter that shares the single synchronous-read memory between the LITE-16 instruction-fetch port, the data load/store port, and the ROM loader/debug port. It sits between the `lite_16` core and the memory array. It issues at most one access per cycle, returns read data one cycle after grant, and supports short locked bursts so a port can finish multi-access sequences uninterrupted.

## Interface
- `ADDR_W`, 16, word-address width.
- `DATA_W`, 16, data word width.
- `MAX_LOCK`, 4, maximum consecutive grants to one locked port (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  3  access request per port; bit 0 fetch, bit 1 data, bit 2 loader.
- `we`  in  3  write enable per port, qualified by `req`.
- `lock`  in  3  request to keep the bus after this grant.
- `addr`  in  3*ADDR_W  per-port address; port i at `[i*ADDR_W +: ADDR_W]`.
- `wdata`  in  3*DATA_W  per-port write data, same packing.
- `gnt`  out  3  one-hot or zero; access accepted this cycle.
- `rvalid`  out  3  one-hot or zero; `rdata` valid for that port.
- `rdata`  out  DATA_W  read data; shared by all ports.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en` without `mem_we`.

## Operation
- Requesters hold `req`, `we`, `addr`, `wdata`, and `lock` stable until `gnt` is seen. A transfer completes in the cycle where `req[i] & gnt[i]`.
- Grant decision is combinational from `req` and registered state. `mem_*` are driven from the granted port in the same cycle. When there is no grant, `mem_en`, `mem_we`, `mem_addr`, and `mem_wdata` are all 0.
- Round robin uses a registered pointer `last`, the last granted port.
  - Search order is `last+1`, `last+2`, `last+3` (mod 3).
  - `last` updates on every grant.
  - Reset value of `last` is 2, so port 0 wins first.
- States:
  - OPEN: normal round robin.
  - LOCKED: only the owner `own` can be granted; other requests wait with `gnt=0`.
- Transitions:
  - OPEN→LOCKED: grant to port i with `lock[i]=1` and `MAX_LOCK>1`. Set `own=i`, `lcnt=1`.
  - In LOCKED, each grant to `own` increments `lcnt`.
  - LOCKED→OPEN, whichever comes first:
    - a grant to `own` with `lock[own]=0`, or `lcnt+1==MAX_LOCK` at grant;
    - `lock[own]` deasserted while `req[own]=0`. This takes effect next cycle; no grant is issued to `own` that cycle.
  - After a forced release at MAX_LOCK, `last=own`, so other ports get priority.
- Read return: a registered `rpend` (3-bit one-hot) is set to `gnt & ~we`.
  - `rvalid = rpend` in the next cycle.
  - `rdata = mem_rdata` combinationally.
  - Writes never produce `rvalid`.
- Back-to-back grants are allowed every cycle, so throughput is 1 access per cycle.
- Reset (at any time, including mid-burst or with a read in flight) forces:
  - state=OPEN, `last`=2, `lcnt`=0, `rpend`=0;
  - in-flight read data is discarded, with no `rvalid` after reset.
- Outputs during `rst`:
  - `gnt`=0, `rvalid`=0, all `mem_*`=0;
  - `rdata` follows `mem_rdata` and is meaningless without `rvalid`.

## Timing
- Grant latency: same cycle as `req` when the port wins.
- Read latency: `rvalid`/`rdata` exactly 1 cycle after `gnt`.
- Write: the memory captures the write at the clock edge ending the grant cycle.
- A port may re-request in the cycle its `rvalid` is high.
- Worst-case wait in OPEN for a requesting port is 2 grants to other ports. With locking, the bound is 2·MAX_LOCK cycles.

## Test plan
- Reset values: hold `rst` for 2 cycles with all `req`=7 -> `gnt`=0, `rvalid`=0, `mem_en`=0. On the first cycle after reset, `gnt`=3'b001.
- Single read: port 0 reads `addr`=0x0010, memory returns 0xBEEF -> `gnt[0]` in cycle t, `mem_addr`=0x0010 and `mem_we`=0 in cycle t; `rvalid`=3'b001 and `rdata`=0xBEEF in cycle t+1.
- Fairness: all three ports request continuously with no lock -> grant sequence 001, 010, 100, 001, 010, 100. Writes from port 1 produce no `rvalid[1]`.
- Lock burst: port 1 holds `lock`=1 for 3 accesses while ports 0 and 2 request, then drops `lock` on the third access -> grants 010, 010, 010, then 100, then 001.
- MAX_LOCK: port 2 holds `lock` continuously with MAX_LOCK=4 and port 0 requesting -> exactly 4 consecutive grants 100, then 001.
- Reset mid-read: `rst` is asserted in the cycle after a port 0 read grant -> `rvalid` stays 0 throughout. The post-reset grant order restarts at port 0.

Source files
------------

// File: rtl/lite_16_mem_arbiter.sv
// lite_16_mem_arbiter
// Three-port round-robin arbiter in front of a single synchronous-read memory
// (port 0 = instruction fetch, port 1 = data load/store, port 2 = ROM loader/debug).
// At most one access per cycle; read data returns one cycle after the grant.
// A port may hold the bus for a short locked burst of up to MAX_LOCK grants.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   req/we/lock     per-port request, write enable, keep-bus request (bit i = port i)
//   addr/wdata      per-port address / write data, port i at [i*W +: W]
//   gnt             one-hot (or zero) grant, combinational
//   rvalid/rdata    one-hot read-return strobe and shared read data
//   mem_*           memory strobe/address/write data, mem_rdata from memory
//
// state  | meaning
// -------+--------------------------------------------------------------
// OPEN   | normal round robin, search order last+1, last+2, last
// LOCKED | only port `own` may be granted; others wait
module lite_16_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [2:0]          we,
  input  logic [2:0]          lock,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  output logic [2:0]          gnt,
  output logic [2:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int LCNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK + 1) : 1;

  typedef enum logic {OPEN, LOCKED} state_t;

  state_t            state;
  logic [1:0]        last;
  logic [1:0]        own;
  logic [LCNT_W-1:0] lcnt;
  logic [2:0]        rpend;

  logic [1:0]        cand1;
  logic [1:0]        cand2;
  logic [1:0]        gidx;
  logic              gany;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    gnt   = '0;
    cand1 = nxt(last);
    cand2 = nxt(cand1);
    if (!rst) begin
      if (state == LOCKED) begin
        if (req[own]) gnt[own] = 1'b1;
      end else if (req[cand1]) begin
        gnt[cand1] = 1'b1;
      end else if (req[cand2]) begin
        gnt[cand2] = 1'b1;
      end else if (req[last]) begin
        gnt[last] = 1'b1;
      end
    end
  end

  always_comb begin
    gany = |gnt;
    gidx = gnt[1] ? 2'd1 : (gnt[2] ? 2'd2 : 2'd0);
  end

  // Memory side is forced to all-zero whenever nothing is granted.
  always_comb begin
    mem_en    = gany;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gany) begin
      mem_we = we[gidx];
      case (gidx)
        2'd1: begin
          mem_addr  = addr[ADDR_W +: ADDR_W];
          mem_wdata = wdata[DATA_W +: DATA_W];
        end
        2'd2: begin
          mem_addr  = addr[2*ADDR_W +: ADDR_W];
          mem_wdata = wdata[2*DATA_W +: DATA_W];
        end
        default: begin
          mem_addr  = addr[ADDR_W-1:0];
          mem_wdata = wdata[DATA_W-1:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OPEN;
      last  <= 2'd2;
      own   <= 2'd0;
      lcnt  <= '0;
      rpend <= '0;
    end else begin
      rpend <= gnt & ~we;
      if (gany) begin
        // A forced release leaves last == own, so the other ports go first.
        last <= gidx;
        if (state == OPEN) begin
          if (lock[gidx] && (MAX_LOCK > 1)) begin
            state <= LOCKED;
            own   <= gidx;
            lcnt  <= LCNT_W'(1);
          end
        end else if (!lock[own] || (lcnt == LCNT_W'(MAX_LOCK - 1))) begin
          state <= OPEN;
          lcnt  <= '0;
        end else begin
          lcnt <= lcnt + LCNT_W'(1);
        end
      end else if ((state == LOCKED) && !req[own] && !lock[own]) begin
        // Owner went idle and gave up the lock: reopen next cycle.
        state <= OPEN;
        lcnt  <= '0;
      end
    end
  end

  // Gated so that a read in flight when reset arrives never shows up.
  assign rvalid = rpend & {3{~rst}};
  assign rdata  = mem_rdata;

endmodule
